// File: rtl/dmem_bus_pkg.sv
// dmem_bus_pkg -- shared types and constants for the data-memory bus controller.
// Holds the controller state encoding, the default error read value and the
// timeout counter width helper.
package dmem_bus_pkg;

  // Controller states: waiting for a core request, owning the bus, one-cycle completion
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUS  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Value returned on read_data whenever an access fails (misaligned or timed out)
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

  // Default number of BUS cycles allowed before giving up on bus_ack
  localparam int TIMEOUT_DEFAULT = 32'd16;

  // Counter width able to hold the value TIMEOUT itself
  localparam int TIMER_W = $clog2(TIMEOUT_DEFAULT + 32'd1);

  // Same width rule for a non-default TIMEOUT
  function automatic int timer_width(input int timeout);
    return $clog2(timeout + 32'd1);
  endfunction

  // Word-align a byte address by clearing the byte-offset bits
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // True when the byte address is on a 32-bit word boundary
  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/dmem_bus_ctrl_timer.sv
// bus_timer -- counts cycles spent in the BUS state and flags the last allowed
// cycle. The count is forced to zero while 'clear' is high, so every bus
// transaction starts with a fresh budget of TIMEOUT cycles.
module bus_timer
  import dmem_bus_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int W       = TIMER_W
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [W-1:0] LAST  = W'(TIMEOUT - 32'd1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT);
  localparam logic [W-1:0] ONE   = W'(32'd1);

  logic [W-1:0] count_r;

  // Count enabled cycles, saturating at TIMEOUT; clear has priority over counting
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {W{1'b0}};
    end else if (clear) begin
      count_r <= {W{1'b0}};
    end else if (enable && (count_r != LIMIT)) begin
      count_r <= count_r + ONE;
    end
  end

  // Expired marks the TIMEOUT-th enabled cycle, so the owner can leave on that edge
  always_comb begin
    expired = enable & (count_r >= LAST);
  end

endmodule

// File: rtl/dmem_bus_ctrl.sv
// dmem_bus_ctrl -- bridges the core's load/store port onto a simple
// request/acknowledge bus. A word-aligned request stalls the core while the
// controller owns the bus, then releases it for exactly one DONE cycle.
// Misaligned requests never reach the bus and report err in the same cycle.
// Build option: define DMEM_BUS_CTRL_WBUF_EN to add a single-entry posted
// write buffer (writes release the core immediately and drain in background).
module dmem_bus_ctrl
  import dmem_bus_pkg::*;
#(
  parameter int          TIMEOUT  = TIMEOUT_DEFAULT,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam int TW = timer_width(TIMEOUT);

  state_e      state_r;
  state_e      state_nxt_s;
  logic        req_s;
  logic        aligned_s;
  logic        go_s;
  logic        finish_s;
  logic        mis_err_s;
  logic        expired_s;
  logic        posted_s;
  logic        timer_clear_s;
  logic        timer_en_s;
  logic        bus_req_r;
  logic        bus_we_r;
  logic        err_r;
  logic [31:0] bus_addr_r;
  logic [31:0] bus_wdata_r;
  logic [31:0] read_data_r;

  assign req_s     = read | write;
  assign aligned_s = is_aligned(address);
  assign go_s      = req_s & aligned_s & (state_r == IDLE);
  // A bus transaction ends on acknowledge or on the last allowed cycle
  assign finish_s  = (state_r == BUS) & (bus_ack | expired_s);

  assign timer_clear_s = (state_r != BUS);
  assign timer_en_s    = (state_r == BUS);

  bus_timer #(
    .TIMEOUT (TIMEOUT),
    .W       (TW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear_s),
    .enable  (timer_en_s),
    .expired (expired_s)
  );

`ifdef DMEM_BUS_CTRL_WBUF_EN
  logic posted_r;

  // Marks the in-flight transaction as a posted write that the core is not waiting on
  always_ff @(posedge clk) begin
    if (rst) begin
      posted_r <= 1'b0;
    end else if (go_s) begin
      posted_r <= write;
    end else if (finish_s) begin
      posted_r <= 1'b0;
    end
  end

  assign posted_s = posted_r;
`else
  assign posted_s = 1'b0;
`endif

  // Next-state selection; posted writes return straight to IDLE with no DONE
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (go_s) begin
          state_nxt_s = BUS;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUS: begin
        if (finish_s) begin
          state_nxt_s = posted_s ? IDLE : DONE;
        end else begin
          state_nxt_s = BUS;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Core stall: held while an aligned request is outstanding, dropped in DONE
  always_comb begin
`ifdef DMEM_BUS_CTRL_WBUF_EN
    // A write accepted from IDLE is posted and does not stall; anything arriving
    // while the buffer drains waits for the drain to complete
    stall = req_s & aligned_s &
            ((state_r == BUS) | ((state_r == IDLE) & ~write));
`else
    stall = req_s & aligned_s & (state_r != DONE);
`endif
  end

  // Misaligned request seen while the controller can answer it immediately
  always_comb begin
    mis_err_s = req_s & ~aligned_s &
                ((state_r == IDLE) | ((state_r == BUS) & posted_s));
  end

  // Main datapath and control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      bus_req_r   <= 1'b0;
      bus_we_r    <= 1'b0;
      bus_addr_r  <= 32'h0000_0000;
      bus_wdata_r <= 32'h0000_0000;
      read_data_r <= 32'h0000_0000;
      err_r       <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      bus_req_r <= (state_nxt_s == BUS);
      // Timeout error is visible for one cycle after expiry: DONE, or IDLE for a posted write
      err_r     <= (state_r == BUS) & ~bus_ack & expired_s;

      // Capture the request on entry to BUS so the bus side stays stable; write wins over read
      if (go_s) begin
        bus_we_r    <= write;
        bus_addr_r  <= word_align(address);
        bus_wdata_r <= write_data;
      end

      // read_data only changes on a completed/failed access and otherwise holds
      if (mis_err_s) begin
        read_data_r <= ERR_DATA;
      end else if ((state_r == BUS) && bus_ack && !bus_we_r) begin
        read_data_r <= bus_rdata;
      end else if ((state_r == BUS) && !bus_ack && expired_s && !posted_s) begin
        read_data_r <= ERR_DATA;
      end
    end
  end

  assign bus_req   = bus_req_r;
  assign bus_we    = bus_we_r;
  assign bus_addr  = bus_addr_r;
  assign bus_wdata = bus_wdata_r;
  // Misaligned errors must present ERR_DATA in the same cycle they are flagged
  assign read_data = mis_err_s ? ERR_DATA : read_data_r;
  assign err       = err_r | mis_err_s;

endmodule

// File: doc/dmem_bus_ctrl.md
DMEM_BUS_CTRL -- requirements
Module: dmem_bus_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Parameter TIMEOUT, default 16, SHALL set the maximum number of cycles spent waiting in BUS for bus_ack.
REQ-003 Parameter ERR_DATA, default 32'hDEADBEEF, SHALL be the read_data value returned on an error.
REQ-004 The block SHALL provide exactly these ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- read  in  1  core load request, held while stall=1
- write  in  1  core store request, held while stall=1
- address  in  32  core byte address (ALU result)
- write_data  in  32  core store data
- read_data  out  32  load result, valid in the DONE cycle
- stall  out  1  freeze PC/register writeback
- err  out  1  one-cycle error pulse
- bus_req  out  1  bus transaction request
- bus_we  out  1  1=write, 0=read
- bus_addr  out  32  word-aligned bus address
- bus_wdata  out  32  bus write data
- bus_rdata  in  32  bus read data
- bus_ack  in  1  bus completion, one cycle

Function
REQ-005 The FSM SHALL have exactly three states: IDLE, BUS and DONE.
REQ-006 IDLE SHALL go to BUS when (read|write) is 1 and address[1:0] is 2'b00; otherwise it SHALL stay in IDLE.
REQ-007 On entry to BUS, the block SHALL latch address, write_data and bus_we; write SHALL take priority when read and write are both 1.
REQ-008 In BUS, bus_req SHALL be 1 and bus_addr/bus_wdata/bus_we SHALL stay stable until bus_ack is sampled.
REQ-009 A bus_ack sampled in BUS SHALL cause: BUS->DONE, read_data <= bus_rdata for reads, and bus_req=0 from the next cycle.
REQ-010 A timeout counter SHALL clear on entry to BUS; reaching TIMEOUT cycles without bus_ack SHALL cause: BUS->DONE, err=1 during DONE, read_data=ERR_DATA.
REQ-011 DONE SHALL last exactly one cycle, then go to IDLE; stall SHALL be 0 during DONE.
REQ-012 stall SHALL be combinational: stall = (read|write) & aligned & (state!=DONE).
- Minimum request-to-release latency: ack in first BUS cycle -> DONE one cycle later -> 2 stalled cycles.
REQ-013 A misaligned request (address[1:0]!=0) SHALL cause: no bus transaction, stall=0, err=1 in the same cycle, read_data=ERR_DATA.
REQ-014 A bus_ack outside BUS SHALL be ignored.
REQ-015 read_data SHALL hold its last value outside DONE.

Reset
REQ-016 Reset SHALL set: state=IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, read_data=0, err=0, timeout counter=0.
REQ-017 Reset asserted mid-BUS SHALL drop bus_req at the next edge; no DONE cycle SHALL occur.

Configuration
REQ-018 The macro DMEM_BUS_CTRL_WBUF_EN SHALL, when defined, enable a single-entry posted write buffer.
- With the macro: a write in IDLE with the buffer empty is latched, stall=0, and the core proceeds with no DONE.
- The buffer then drains through BUS; a timeout on a posted write pulses err on expiry.
- Any read or write while the buffer is occupied SHALL stall until the drain completes, then SHALL be processed normally.
REQ-019 Without the macro, every write SHALL follow REQ-006..REQ-012 exactly.

Structure
REQ-020 Package dmem_bus_pkg SHALL hold the state enum (IDLE/BUS/DONE), the default ERR_DATA constant and the width constant TIMER_W = $clog2(TIMEOUT+1).
REQ-021 The timeout counter SHALL be a sub-module bus_timer (inputs clear/enable, output expired).

Verification
REQ-022 Read 0x100, bus_ack in first BUS cycle, bus_rdata=0x12345678 -> 2 stall cycles, read_data=0x12345678 in DONE, err=0.
REQ-023 Write 0x200/0xCAFEF00D, ack after 5 cycles -> bus_we=1, bus_addr=0x200, bus_wdata stable throughout, stall released on the cycle after ack.
REQ-024 Read 0x300, no ack -> exactly TIMEOUT BUS cycles, then DONE with err=1 and read_data=0xDEADBEEF.
REQ-025 Read 0x102 -> bus_req stays 0, stall=0, err=1 in the same cycle.
REQ-026 rst asserted in BUS cycle 3 -> bus_req=0 next cycle, state IDLE, no DONE pulse.
REQ-027 With DMEM_BUS_CTRL_WBUF_EN: write then back-to-back read -> write has 0 stall, read stalls until the write ack, then completes normally.
